// File: rtl/md_pkg.sv
// Shared op codes, FSM state encoding and divider constants for the HI/LO sequencer.
package md_pkg;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIN} state_e;

  localparam int DIV_ITERS = 32;

  // Magnitude of a possibly-signed operand; 32'h8000_0000 maps to itself as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn & v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/md_div_core.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
// quo/rem carry the result of the current iteration so the owner can capture on last.
module md_div_core #(
  parameter int ITERS = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        last,
  output logic [31:0] quo,
  output logic [31:0] rem
);
  localparam int CW = $clog2(ITERS);

  logic          busy;
  logic [CW-1:0] cnt;
  logic [31:0]   q_r, r_r, d_r;
  logic [32:0]   r_sh, diff;

  always_comb begin
    r_sh = {r_r, q_r[31]};
    diff = r_sh - {1'b0, d_r};
    quo  = {q_r[30:0], ~diff[32]};
    rem  = diff[32] ? r_sh[31:0] : diff[31:0];
  end

  assign last = busy & (cnt == CW'(ITERS - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy <= 1'b0;
      cnt  <= '0;
      q_r  <= '0;
      r_r  <= '0;
      d_r  <= '0;
    end else if (abort) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      q_r  <= dividend;
      r_r  <= '0;
      d_r  <= divisor;
    end else if (busy) begin
      q_r  <= quo;
      r_r  <= rem;
      cnt  <= cnt + 1'b1;
      if (last) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/md_hilo_ctrl.sv
// Multiply/divide sequencer and HI/LO owner for EX. Define MD_DIV_EN to build the
// divider; without it DIV/DIVU are no-ops.
module md_hilo_ctrl
  import md_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic [2:0]  ex_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        md_stall,
  output logic        md_done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e state;

  logic is_mul, md_op, mul_go, mul_sgn;
  logic signed [63:0] ma, mb;
  logic [63:0] mp;
  logic [MUL_LAT-1:0] vld_pipe;
  logic [63:0] prod_pipe [MUL_LAT];

  assign is_mul  = (ex_op == OP_MULT) || (ex_op == OP_MULTU);
  assign mul_sgn = (ex_op == OP_MULT);
  assign mul_go  = (state == ST_IDLE) & ex_valid & is_mul & ~flush;

`ifdef MD_DIV_EN
  logic        is_div, div_sgn, div_go, div_last, neg_q, neg_r;
  logic [31:0] div_q, div_r;

  assign is_div  = (ex_op == OP_DIV) || (ex_op == OP_DIVU);
  assign div_sgn = (ex_op == OP_DIV);
  assign div_go  = (state == ST_IDLE) & ex_valid & is_div & (rt_val != 32'd0) & ~flush;
  assign md_op   = is_mul | is_div;

  md_div_core #(.ITERS(DIV_ITERS)) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .start    (div_go),
    .abort    (flush),
    .dividend (mag32(rs_val, div_sgn)),
    .divisor  (mag32(rt_val, div_sgn)),
    .last     (div_last),
    .quo      (div_q),
    .rem      (div_r)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (div_go) begin
      neg_q <= div_sgn & (rs_val[31] ^ rt_val[31]);
      neg_r <= div_sgn & rs_val[31];
    end
  end
`else
  assign md_op = is_mul;
`endif

  // Operands are sign-extended to 64 bits so the low 64 product bits are exact for both signednesses.
  assign ma = {{32{mul_sgn & rs_val[31]}}, rs_val};
  assign mb = {{32{mul_sgn & rt_val[31]}}, rt_val};
  assign mp = ma * mb;

  always_ff @(posedge clk) begin
    if (mul_go) prod_pipe[0] <= mp;
    for (int i = 1; i < MUL_LAT; i++) prod_pipe[i] <= prod_pipe[i-1];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) vld_pipe <= '0;
    else begin
      vld_pipe[0] <= mul_go;
      for (int i = 1; i < MUL_LAT; i++) vld_pipe[i] <= vld_pipe[i-1] & ~flush;
    end
  end

  always_comb begin
    md_stall = 1'b0;
    case (state)
      ST_IDLE:        md_stall = ex_valid & md_op & ~flush;
      ST_MUL, ST_DIV: md_stall = ~flush;
      default:        md_stall = 1'b0;
    endcase
    md_stall = md_stall & resetn;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      hi      <= '0;
      lo      <= '0;
      md_done <= 1'b0;
    end else begin
      md_done <= 1'b0;
      if (flush) state <= ST_IDLE;
      else begin
        case (state)
          ST_IDLE: if (ex_valid) begin
            case (ex_op)
              OP_MTHI:           hi <= rs_val;
              OP_MTLO:           lo <= rs_val;
              OP_MULT, OP_MULTU: state <= ST_MUL;
`ifdef MD_DIV_EN
              OP_DIV, OP_DIVU: begin
                if (rt_val == 32'd0) begin
                  lo      <= 32'hFFFF_FFFF;
                  hi      <= rs_val;
                  state   <= ST_FIN;
                  md_done <= 1'b1;
                end else state <= ST_DIV;
              end
`endif
              default: ;
            endcase
          end
          ST_MUL: if (vld_pipe[MUL_LAT-1]) begin
            {hi, lo} <= prod_pipe[MUL_LAT-1];
            state    <= ST_FIN;
            md_done  <= 1'b1;
          end
`ifdef MD_DIV_EN
          ST_DIV: if (div_last) begin
            lo      <= neg_q ? (32'd0 - div_q) : div_q;
            hi      <= neg_r ? (32'd0 - div_r) : div_r;
            state   <= ST_FIN;
            md_done <= 1'b1;
          end
`endif
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_md_hilo_ctrl.sv
// Directed bench for md_hilo_ctrl: reset, MTHI/MTLO, multiplies, flush, and divides or
// divide no-ops depending on MD_DIV_EN.
module tb_md_hilo_ctrl;
  import md_pkg::*;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0, resetn = 1'b0, ex_valid = 1'b0, flush = 1'b0;
  logic [2:0]  ex_op = OP_NONE;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic        md_stall, md_done;
  logic [31:0] hi, lo;

  int n_run = 0, n_fail = 0;
  logic [31:0] cur_hi = '0, cur_lo = '0;

  md_hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_op(ex_op),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
    .md_stall(md_stall), .md_done(md_done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic f);
    ex_valid = v; ex_op = op; rs_val = a; rt_val = b; flush = f;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Op held in EX for n stall cycles, then FIN with the expected HI/LO.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] ehi,
                        input logic [31:0] elo);
    drive(1'b1, op, a, b, 1'b0);
    for (int c = 0; c < n; c++) begin
      @(negedge clk); chk({tag, "/stall"}, {62'd0, md_stall, md_done}, 64'd2);
      step();
    end
    @(negedge clk);
    chk({tag, "/fin"}, {62'd0, md_stall, md_done}, 64'd1);
    chk({tag, "/hilo"}, {hi, lo}, {ehi, elo});
    step();
    drive(1'b0, OP_NONE, '0, '0, 1'b0);
    cur_hi = ehi; cur_lo = elo;
    @(negedge clk);
    chk({tag, "/post"}, {63'd0, md_done}, 64'd0);
    step();
  endtask

  // Watch k idle cycles: no md_done pulse, HI/LO unchanged.
  task automatic quiet(input string tag, input int k);
    int dn;
    dn = 0;
    for (int c = 0; c < k; c++) begin
      @(negedge clk); if (md_done) dn++;
      step();
    end
    chk({tag, "/nodone"}, 64'(dn), 64'd0);
    chk({tag, "/keep"}, {hi, lo}, {cur_hi, cur_lo});
  endtask

  initial begin
    // reset state
    repeat (2) step();
    @(negedge clk);
    chk("rst/hilo", {hi, lo}, 64'd0);
    chk("rst/ctl", {62'd0, md_stall, md_done}, 64'd0);
    step();
    resetn = 1'b1;

    // MTLO then MTHI on consecutive cycles, never stalling
    drive(1'b1, OP_MTLO, 32'h1234_5678, '0, 1'b0);
    @(negedge clk); chk("mtlo/stall", {63'd0, md_stall}, 64'd0);
    step();
    drive(1'b1, OP_MTHI, 32'hA5A5_A5A5, '0, 1'b0);
    @(negedge clk);
    chk("mtlo/lo", {32'd0, lo}, 64'h1234_5678);
    chk("mthi/stall", {63'd0, md_stall}, 64'd0);
    step();
    drive(1'b0, OP_NONE, '0, '0, 1'b0);
    @(negedge clk); chk("mthi/hilo", {hi, lo}, 64'hA5A5_A5A5_1234_5678);
    cur_hi = 32'hA5A5_A5A5; cur_lo = 32'h1234_5678;
    step();

    // flush in IDLE blocks MTHI
    drive(1'b1, OP_MTHI, 32'hDEAD_BEEF, '0, 1'b1);
    @(negedge clk); chk("mthi_fl/stall", {63'd0, md_stall}, 64'd0);
    step();
    drive(1'b0, OP_NONE, '0, '0, 1'b0);
    @(negedge clk); chk("mthi_fl/hilo", {hi, lo}, {cur_hi, cur_lo});
    step();

    // multiplies
    run_op("mult_m3x5", OP_MULT,  32'hFFFF_FFFD, 32'd5,        MUL_LAT+1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu_ff2", OP_MULTU, 32'hFFFF_FFFF, 32'd2,        MUL_LAT+1, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("mult_m1x2", OP_MULT,  32'hFFFF_FFFF, 32'd2,        MUL_LAT+1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mult_min2", OP_MULT,  32'h8000_0000, 32'h8000_0000, MUL_LAT+1, 32'h4000_0000, 32'h0000_0000);
    run_op("mult_max2", OP_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, MUL_LAT+1, 32'h3FFF_FFFF, 32'h0000_0001);

    // flush in cycle 1 of a MULT
    drive(1'b1, OP_MULT, 32'd9, 32'd9, 1'b0);
    @(negedge clk); chk("mul_fl/c0", {63'd0, md_stall}, 64'd1);
    step();
    flush = 1'b1;
    @(negedge clk); chk("mul_fl/c1", {63'd0, md_stall}, 64'd0);
    step();
    drive(1'b0, OP_NONE, '0, '0, 1'b0);
    quiet("mul_fl", 6);

`ifdef MD_DIV_EN
    run_op("div_m7_2",  OP_DIV,  32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_7_0",  OP_DIVU, 32'd7,         32'd0,         1,  32'd7,         32'hFFFF_FFFF);
    run_op("div_ovf",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0,         32'h8000_0000);
    run_op("divu_100_3",OP_DIVU, 32'd100,       32'd3,         33, 32'd1,         32'd33);

    // DIVU 100/3 flushed in cycle 5
    drive(1'b1, OP_DIVU, 32'd100, 32'd3, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); chk("div_fl/stall", {63'd0, md_stall}, 64'd1);
      step();
    end
    flush = 1'b1;
    @(negedge clk); chk("div_fl/c5", {63'd0, md_stall}, 64'd0);
    step();
    drive(1'b0, OP_NONE, '0, '0, 1'b0);
    @(negedge clk); chk("div_fl/idle", {62'd0, md_stall, md_done}, 64'd0);
    step();
    quiet("div_fl", 40);
`else
    drive(1'b1, OP_DIV, 32'd10, 32'd2, 1'b0);
    @(negedge clk); chk("div_off/stall", {62'd0, md_stall, md_done}, 64'd0);
    step();
    drive(1'b0, OP_NONE, '0, '0, 1'b0);
    quiet("div_off", 4);
    drive(1'b1, OP_DIVU, 32'd7, 32'd0, 1'b0);
    @(negedge clk); chk("div0_off/stall", {62'd0, md_stall, md_done}, 64'd0);
    step();
    drive(1'b0, OP_NONE, '0, '0, 1'b0);
    quiet("div0_off", 4);
`endif

    // reset in the middle of a long op
`ifdef MD_DIV_EN
    drive(1'b1, OP_DIV, 32'd1000, 32'd7, 1'b0);
    repeat (10) step();
`else
    drive(1'b1, OP_MULT, 32'd1000, 32'd7, 1'b0);
    repeat (1) step();
`endif
    resetn = 1'b0;
    #1;
    chk("rst_mid/hilo", {hi, lo}, 64'd0);
    chk("rst_mid/stall", {63'd0, md_stall}, 64'd0);
    drive(1'b0, OP_NONE, '0, '0, 1'b0);
    step();
    resetn = 1'b1;
    cur_hi = '0; cur_lo = '0;
    quiet("rst_mid", 5);
    run_op("mult_after", OP_MULT, 32'd6, 32'hFFFF_FFFE, MUL_LAT+1, 32'hFFFF_FFFF, 32'hFFFF_FFF4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/md_hilo_ctrl.md
# md_hilo_ctrl

Multi-cycle multiply/divide sequencer and HI/LO register owner for the EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs multiplies over a fixed latency and divides iteratively. It stalls the pipeline while busy and writes HI/LO either from the arithmetic result or directly from the rs operand for MTHI/MTLO. Its hi/lo outputs feed the MFHI/MFLO path.

## Interface
- MUL_LAT, 2: cycles spent in MUL state (1..8); multiply is a registered 32x32 product retimed over this many stages.
- clk  in  1  pipeline clock.
- resetn  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX holds a valid instruction.
- ex_op  in  3  md_pkg op code: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- rs_val  in  32  forwarded rs (dividend / multiplicand / MTHI, MTLO source).
- rt_val  in  32  forwarded rt (divisor / multiplier).
- flush  in  1  squash EX; aborts any in-flight operation.
- md_stall  out  1  hold IF/ID/EX.
- md_done  out  1  one-cycle pulse in FIN.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- States: IDLE, MUL, DIV, FIN.
- IDLE:
  - ex_valid & MTHI writes hi <= rs_val at the edge; MTLO writes lo <= rs_val. No stall; remain IDLE.
  - ex_valid & MULT/MULTU latches operands and goes to MUL.
  - ex_valid & DIV/DIVU with rt_val != 0 latches operands and goes to DIV.
  - ex_valid & DIV/DIVU with rt_val == 0 writes lo <= 32'hFFFF_FFFF, hi <= rs_val, and goes to FIN.
- MUL: counts MUL_LAT cycles. On the last one it writes {hi,lo} <= 64-bit product (signed for MULT, unsigned for MULTU) and goes to FIN.
- DIV: runs 32 restoring iterations on operand magnitudes. On the 32nd it applies signs (DIV: quotient negated if signs differ, remainder takes dividend sign), writes lo <= quotient, hi <= remainder, and goes to FIN.
- FIN: md_done=1, md_stall=0, all inputs ignored; next state IDLE unconditionally. This lets the stalled instruction leave EX without restarting.
- md_stall = ex_valid & (MULT|MULTU|DIV|DIVU) & ~flush in IDLE; 1 & ~flush in MUL/DIV; 0 in FIN.
- flush in any state: state <= IDLE at next edge, hi/lo unchanged, no write, md_done stays 0. In IDLE, flush blocks the MTHI/MTLO write.
- DIV of 32'h8000_0000 by -1: lo=32'h8000_0000, hi=0 (natural wrap).
- ex_op NONE or ex_valid=0: no effect.

## Timing
- Reset: state IDLE, hi=0, lo=0, md_stall=0, md_done=0, counters 0.
- Op accepted in cycle 0.
- MULT/MULTU: md_stall high cycles 0..MUL_LAT; hi/lo new in cycle MUL_LAT+1 (FIN).
- DIV/DIVU: md_stall high cycles 0..32; hi/lo new in cycle 33 (FIN).
- Divide by zero: md_stall high cycle 0 only; hi/lo new in cycle 1 (FIN).
- MTHI/MTLO: visible on hi/lo in cycle 1, zero stall.
- Back-to-back: the earliest next accept is the cycle after FIN.

## Configuration
- MD_DIV_EN defined: divider present as above.
- MD_DIV_EN undefined: DIV state and divider removed; DIV/DIVU are no-ops (no stall, hi/lo unchanged, no md_done).

## Structure
- md_pkg holds:
  - op encoding localparams (NONE=0, MULT, MULTU, DIV, DIVU, MTHI, MTLO);
  - state encoding;
  - DIV_ITERS=32.
- Sub-module md_div_core: iterative restoring divider with a start/iteration-count interface, instantiated only under MD_DIV_EN. The controller owns the FSM, sign fix and HI/LO registers.

## Test plan
- Reset mid-DIV (resetn low in cycle 10) -> hi=lo=0, md_stall=0 immediately, state IDLE.
- MULT rs=-3, rt=5, MUL_LAT=2 -> md_stall cycles 0..2; cycle 3: hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF1, md_done=1.
- DIV rs=-7, rt=2 -> md_stall 33 cycles; cycle 33: lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF. DIVU 7/0 -> lo=32'hFFFF_FFFF, hi=7 in cycle 1.
- MTLO rs=32'h1234_5678 then MTHI rs=32'hA5A5_A5A5 on consecutive cycles -> lo, hi updated the next cycle each, md_stall never asserted.
- DIVU 100/3 with flush in cycle 5 -> md_stall low the same cycle, IDLE next, hi/lo keep prior values, no md_done.
- MD_DIV_EN undefined: DIV 10/2 -> no stall, hi/lo unchanged.
